voice_envelope_bank: RTL and testbench

Time-multiplexed, parametrised envelope generator bank for the synthesiser voice path. It holds one multi-stage envelope state machine per voice and advances every voice once per envelope tick through a shared scan slot. Compared with the single-table envelope embedded in the oscillator, it adds:
- explicit key-on/key-off events with a sustain hold and a release jump;
- an idle detect;
- a selectable retrigger mode;
- a registered gain read port consumed by the oscillator multiplier.

---
 rtl/voice_envelope_bank_if.sv | 34 +++
 rtl/voice_envelope_bank.sv | 204 ++++++++++++++++++++
 tb/tb_voice_envelope_bank.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_envelope_bank_if.sv
// Control/read bus of the envelope bank: key events, shared stage table and the gain read port.
interface voice_envelope_bank_if #(
    parameter int N_VOICES   = 16,
    parameter int N_STAGES   = 8,
    parameter int GAIN_WIDTH = 16,
    parameter int RATE_WIDTH = 17,
    parameter int DUR_WIDTH  = 16
);
    localparam int SW  = $clog2(N_STAGES);
    localparam int RDW = $clog2(N_VOICES + 1);

    logic [N_VOICES-1:0]             key_on_i;
    logic [N_VOICES-1:0]             key_off_i;
    logic [N_STAGES*RATE_WIDTH-1:0]  stage_rate_i;
    logic [N_STAGES*DUR_WIDTH-1:0]   stage_dur_i;
    logic [SW-1:0]                   sustain_stage_i;
    logic [SW-1:0]                   release_stage_i;
    logic [RDW-1:0]                  rd_voice_i;
    logic [GAIN_WIDTH-1:0]           rd_gain_o;
    logic [N_VOICES-1:0]             active_o;
    logic                            tick_o;

    modport master (
        output key_on_i, key_off_i, stage_rate_i, stage_dur_i,
        output sustain_stage_i, release_stage_i, rd_voice_i,
        input  rd_gain_o, active_o, tick_o
    );

    modport slave (
        input  key_on_i, key_off_i, stage_rate_i, stage_dur_i,
        input  sustain_stage_i, release_stage_i, rd_voice_i,
        output rd_gain_o, active_o, tick_o
    );
endinterface

// File: rtl/voice_envelope_bank.sv
// Time-multiplexed envelope bank: one envelope FSM per voice, each advanced once per tick
// in its own scan slot of a shared prescaler, with a registered gain read port.
module voice_envelope_bank #(
    parameter int N_VOICES       = 16,
    parameter int N_STAGES       = 8,
    parameter int GAIN_WIDTH     = 16,
    parameter int RATE_WIDTH     = 17,
    parameter int DUR_WIDTH      = 16,
    parameter int TICK_CYCLES    = 48,
    parameter int RETRIGGER_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    voice_envelope_bank_if.slave  bus
);
    localparam int VW    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int SW    = $clog2(N_STAGES);
    localparam int CW    = $clog2(TICK_CYCLES);
    localparam int RDW   = $clog2(N_VOICES + 1);
    localparam int SUM_W = GAIN_WIDTH + 2;
    localparam logic [CW:0]           NV_C     = (CW+1)'(N_VOICES);
    localparam logic [CW-1:0]         CNT_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = {GAIN_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_e;

    env_state_e              state_q [N_VOICES];
    logic [SW-1:0]           stage_q [N_VOICES];
    logic [DUR_WIDTH-1:0]    dur_q   [N_VOICES];
    logic [GAIN_WIDTH-1:0]   gain_q  [N_VOICES];
    logic [N_VOICES-1:0]     pend_on_q;
    logic [N_VOICES-1:0]     pend_off_q;
    logic [N_VOICES-1:0]     active_q;
    logic [CW-1:0]           cnt_q;
    logic                    tick_q;
    logic [GAIN_WIDTH-1:0]   rd_gain_q;

    logic                    slot_vld_d;
    logic [VW-1:0]           slot_v_d;
    logic [N_VOICES-1:0]     slot_hit_d;
    env_state_e              cur_state_d;
    logic [SW-1:0]           cur_stage_d;
    logic [DUR_WIDTH-1:0]    cur_dur_d;
    logic [GAIN_WIDTH-1:0]   cur_gain_d;
    logic                    ev_on_d;
    logic                    ev_off_d;
    logic [RATE_WIDTH-1:0]   rate_d;
    logic [DUR_WIDTH-1:0]    dur_lim_d;
    logic signed [SUM_W-1:0] sum_d;
    logic [GAIN_WIDTH-1:0]   clamp_d;
    env_state_e              state_d;
    logic [SW-1:0]           stage_d;
    logic [DUR_WIDTH-1:0]    dur_d;
    logic [GAIN_WIDTH-1:0]   gain_d;
    logic [GAIN_WIDTH-1:0]   rd_sel_d;

    // Slot decode and fetch of the serviced voice's state, its events and its stage table entry.
    always_comb begin
        slot_vld_d = ({1'b0, cnt_q} < NV_C);
        slot_v_d   = cnt_q[VW-1:0];
        slot_hit_d = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (slot_vld_d && (slot_v_d == VW'(v))) begin
                slot_hit_d[v] = 1'b1;
            end else begin
                slot_hit_d[v] = 1'b0;
            end
        end
        cur_state_d = state_q[slot_v_d];
        cur_stage_d = stage_q[slot_v_d];
        cur_dur_d   = dur_q[slot_v_d];
        cur_gain_d  = gain_q[slot_v_d];
        // A pulse landing in the slot cycle itself is consumed right away.
        ev_on_d     = pend_on_q[slot_v_d]  | bus.key_on_i[slot_v_d];
        ev_off_d    = pend_off_q[slot_v_d] | bus.key_off_i[slot_v_d];
        rate_d      = bus.stage_rate_i[cur_stage_d*RATE_WIDTH +: RATE_WIDTH];
        dur_lim_d   = bus.stage_dur_i[cur_stage_d*DUR_WIDTH +: DUR_WIDTH];
    end

    // Saturating gain step; the two guard bits hold both the sign and the overflow carry.
    always_comb begin
        sum_d = $signed({2'b00, cur_gain_d})
              + $signed({{(SUM_W-RATE_WIDTH){rate_d[RATE_WIDTH-1]}}, rate_d});
        if (sum_d[SUM_W-1]) begin
            clamp_d = '0;
        end else if (sum_d[SUM_W-2:GAIN_WIDTH] != '0) begin
            clamp_d = GAIN_MAX;
        end else begin
            clamp_d = sum_d[GAIN_WIDTH-1:0];
        end
    end

    // Next envelope state of the serviced voice; key events take priority over the stage timer.
    always_comb begin
        state_d = cur_state_d;
        stage_d = cur_stage_d;
        dur_d   = cur_dur_d;
        gain_d  = cur_gain_d;
        if (ev_on_d) begin
            state_d = ST_RUN;
            stage_d = '0;
            dur_d   = '0;
            if (RETRIGGER_MODE == 0) begin
                gain_d = '0;
            end else begin
                gain_d = cur_gain_d;
            end
        end else if (ev_off_d) begin
            if (cur_state_d != ST_IDLE) begin
                state_d = ST_RELEASE;
                stage_d = bus.release_stage_i;
                dur_d   = '0;
            end else begin
                state_d = cur_state_d;
            end
        end else begin
            case (cur_state_d)
                ST_RUN, ST_RELEASE: begin
                    gain_d = clamp_d;
                    if (cur_dur_d >= dur_lim_d) begin
                        dur_d = '0;
                        if ((cur_state_d == ST_RUN) && (cur_stage_d == bus.sustain_stage_i)) begin
                            state_d = ST_SUSTAIN;
                        end else if ((cur_state_d == ST_RELEASE) && (cur_stage_d == SW'(N_STAGES - 1))) begin
                            stage_d = cur_stage_d;
                        end else begin
                            stage_d = cur_stage_d + SW'(1);
                        end
                    end else begin
                        dur_d = cur_dur_d + DUR_WIDTH'(1);
                    end
                    if ((cur_state_d == ST_RELEASE) && (clamp_d == '0)) begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                        dur_d   = '0;
                    end else begin
                        state_d = state_d;
                    end
                end
                default: begin
                    gain_d = cur_gain_d;
                end
            endcase
        end
    end

    // Read-port mux; any address past the last voice reads as zero.
    always_comb begin
        rd_sel_d = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (bus.rd_voice_i == RDW'(v)) begin
                rd_sel_d = gain_q[v];
            end else begin
                rd_sel_d = rd_sel_d;
            end
        end
    end

    // Prescaler, event latches, per-voice state write-back and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            rd_gain_q  <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            active_q   <= '0;
            for (int v = 0; v < N_VOICES; v++) begin
                state_q[v] <= ST_IDLE;
                stage_q[v] <= '0;
                dur_q[v]   <= '0;
                gain_q[v]  <= '0;
            end
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            tick_q     <= (cnt_q == '0);
            rd_gain_q  <= rd_sel_d;
            pend_on_q  <= (pend_on_q  | bus.key_on_i)  & ~slot_hit_d;
            pend_off_q <= (pend_off_q | bus.key_off_i) & ~slot_hit_d;
            if (slot_vld_d) begin
                state_q[slot_v_d]  <= state_d;
                stage_q[slot_v_d]  <= stage_d;
                dur_q[slot_v_d]    <= dur_d;
                gain_q[slot_v_d]   <= gain_d;
                active_q[slot_v_d] <= (state_d != ST_IDLE);
            end else begin
                active_q <= active_q;
            end
        end
    end

    assign bus.rd_gain_o = rd_gain_q;
    assign bus.active_o  = active_q;
    assign bus.tick_o    = tick_q;
endmodule

// File: tb/tb_voice_envelope_bank.sv
// Bench for voice_envelope_bank: directed vector table, reset sequence and random traffic,
// with both retrigger variants run side by side against a behavioural envelope model.
module tb_voice_envelope_bank;
    localparam int NV = 4;
    localparam int NS = 8;
    localparam int GW = 16;
    localparam int RW = 17;
    localparam int DW = 16;
    localparam int TC = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_SUS = 2, M_REL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    voice_envelope_bank_if #(.N_VOICES(NV), .N_STAGES(NS), .GAIN_WIDTH(GW), .RATE_WIDTH(RW), .DUR_WIDTH(DW)) bus0 ();
    voice_envelope_bank_if #(.N_VOICES(NV), .N_STAGES(NS), .GAIN_WIDTH(GW), .RATE_WIDTH(RW), .DUR_WIDTH(DW)) bus1 ();

    assign bus1.key_on_i        = bus0.key_on_i;
    assign bus1.key_off_i       = bus0.key_off_i;
    assign bus1.stage_rate_i    = bus0.stage_rate_i;
    assign bus1.stage_dur_i     = bus0.stage_dur_i;
    assign bus1.sustain_stage_i = bus0.sustain_stage_i;
    assign bus1.release_stage_i = bus0.release_stage_i;
    assign bus1.rd_voice_i      = bus0.rd_voice_i;

    voice_envelope_bank #(.N_VOICES(NV), .N_STAGES(NS), .GAIN_WIDTH(GW), .RATE_WIDTH(RW),
                          .DUR_WIDTH(DW), .TICK_CYCLES(TC), .RETRIGGER_MODE(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    voice_envelope_bank #(.N_VOICES(NV), .N_STAGES(NS), .GAIN_WIDTH(GW), .RATE_WIDTH(RW),
                          .DUR_WIDTH(DW), .TICK_CYCLES(TC), .RETRIGGER_MODE(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int n_total = 0;
    int n_bad   = 0;

    int rate_tab [NS];
    int dur_tab  [NS];
    int sus_stage;
    int rel_stage;

    // Reference model, indexed [retrigger mode][voice]
    int m_state [2][NV];
    int m_stage [2][NV];
    int m_dur   [2][NV];
    int m_gain  [2][NV];
    bit m_pon   [2][NV];
    bit m_poff  [2][NV];
    int m_cnt;
    int exp_rd   [2];
    int exp_tick [2];
    int exp_act  [2];

    typedef struct {
        logic [3:0]  kon;
        logic [3:0]  koff;
        logic [2:0]  rd;
        logic [15:0] g0;
        logic [15:0] g1;
        logic [3:0]  act;
    } vec_t;
    vec_t tbl [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack_tabs();
        for (int s = 0; s < NS; s++) begin
            bus0.stage_rate_i[s*RW +: RW] = RW'(rate_tab[s]);
            bus0.stage_dur_i[s*DW +: DW]  = DW'(dur_tab[s]);
        end
        bus0.sustain_stage_i = 3'(sus_stage);
        bus0.release_stage_i = 3'(rel_stage);
    endtask

    task automatic service(input int m, input int v);
        int g;
        int old_state;
        old_state = m_state[m][v];
        if (m_pon[m][v]) begin
            m_state[m][v] = M_RUN;
            m_stage[m][v] = 0;
            m_dur[m][v]   = 0;
            if (m == 0) m_gain[m][v] = 0;
        end else if (m_poff[m][v]) begin
            if (old_state != M_IDLE) begin
                m_state[m][v] = M_REL;
                m_stage[m][v] = rel_stage;
                m_dur[m][v]   = 0;
            end
        end else if (old_state == M_RUN || old_state == M_REL) begin
            g = m_gain[m][v] + rate_tab[m_stage[m][v]];
            if (g < 0) g = 0;
            if (g > 65535) g = 65535;
            m_gain[m][v] = g;
            if (m_dur[m][v] >= dur_tab[m_stage[m][v]]) begin
                m_dur[m][v] = 0;
                if (old_state == M_RUN && m_stage[m][v] == sus_stage) m_state[m][v] = M_SUS;
                else if (old_state == M_REL && m_stage[m][v] == NS - 1) m_stage[m][v] = NS - 1;
                else m_stage[m][v] = (m_stage[m][v] + 1) % NS;
            end else begin
                m_dur[m][v] = m_dur[m][v] + 1;
            end
            if (old_state == M_REL && g == 0) begin
                m_state[m][v] = M_IDLE;
                m_stage[m][v] = 0;
                m_dur[m][v]   = 0;
            end
        end
        m_pon[m][v]  = 1'b0;
        m_poff[m][v] = 1'b0;
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (bus0.rd_voice_i < NV) exp_rd[m] = m_gain[m][bus0.rd_voice_i];
            else exp_rd[m] = 0;
            if (rst) begin
                exp_rd[m]   = 0;
                exp_tick[m] = 0;
                for (int v = 0; v < NV; v++) begin
                    m_state[m][v] = M_IDLE; m_stage[m][v] = 0; m_dur[m][v] = 0;
                    m_gain[m][v]  = 0; m_pon[m][v] = 1'b0; m_poff[m][v] = 1'b0;
                end
            end else begin
                exp_tick[m] = (m_cnt == 0) ? 1 : 0;
                for (int v = 0; v < NV; v++) begin
                    if (bus0.key_on_i[v])  m_pon[m][v]  = 1'b1;
                    if (bus0.key_off_i[v]) m_poff[m][v] = 1'b1;
                end
                if (m_cnt < NV) service(m, m_cnt);
            end
            exp_act[m] = 0;
            for (int v = 0; v < NV; v++)
                if (m_state[m][v] != M_IDLE) exp_act[m] = exp_act[m] | (1 << v);
        end
        m_cnt = rst ? 0 : (m_cnt + 1) % TC;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m0_rd_gain", 32'(bus0.rd_gain_o), 32'(exp_rd[0]));
        chk("m1_rd_gain", 32'(bus1.rd_gain_o), 32'(exp_rd[1]));
        chk("m0_active",  32'(bus0.active_o),  32'(exp_act[0]));
        chk("m1_active",  32'(bus1.active_o),  32'(exp_act[1]));
        chk("m0_tick",    32'(bus0.tick_o),    32'(exp_tick[0]));
        chk("m1_tick",    32'(bus1.tick_o),    32'(exp_tick[1]));
    endtask

    task automatic sync_tick();
        int k = 0;
        while (bus0.tick_o !== 1'b1 && k < 2*TC) begin
            cyc();
            k++;
        end
        if (bus0.tick_o !== 1'b1) chk("sync_tick_timeout", 32'(bus0.tick_o), 32'd1);
    endtask

    initial begin
        //             kon      koff     rd    g0      g1      act
        tbl[0]  = '{4'b0010, 4'b0000, 3'd1, 16'd0,     16'd0,     4'b0010};
        tbl[1]  = '{4'b0000, 4'b0000, 3'd1, 16'd30000, 16'd30000, 4'b0010};
        tbl[2]  = '{4'b0000, 4'b0000, 3'd1, 16'd60000, 16'd60000, 4'b0010};
        tbl[3]  = '{4'b0000, 4'b0000, 3'd1, 16'd65535, 16'd65535, 4'b0010};
        tbl[4]  = '{4'b0000, 4'b0000, 3'd1, 16'd65535, 16'd65535, 4'b0010};
        tbl[5]  = '{4'b0000, 4'b0000, 3'd1, 16'd65535, 16'd65535, 4'b0010};
        tbl[6]  = '{4'b0000, 4'b0010, 3'd1, 16'd65535, 16'd65535, 4'b0010};
        tbl[7]  = '{4'b0000, 4'b0000, 3'd1, 16'd45535, 16'd45535, 4'b0010};
        tbl[8]  = '{4'b0000, 4'b0000, 3'd1, 16'd25535, 16'd25535, 4'b0010};
        tbl[9]  = '{4'b0000, 4'b0000, 3'd1, 16'd5535,  16'd5535,  4'b0010};
        tbl[10] = '{4'b0000, 4'b0000, 3'd1, 16'd0,     16'd0,     4'b0000};
        tbl[11] = '{4'b0000, 4'b0010, 3'd1, 16'd0,     16'd0,     4'b0000};
        tbl[12] = '{4'b0100, 4'b0100, 3'd2, 16'd0,     16'd0,     4'b0100};
        tbl[13] = '{4'b0000, 4'b0000, 3'd2, 16'd30000, 16'd30000, 4'b0100};
        tbl[14] = '{4'b0000, 4'b0100, 3'd2, 16'd30000, 16'd30000, 4'b0100};
        tbl[15] = '{4'b0000, 4'b0000, 3'd2, 16'd10000, 16'd10000, 4'b0100};
        tbl[16] = '{4'b0000, 4'b0000, 3'd2, 16'd0,     16'd0,     4'b0000};
        tbl[17] = '{4'b0010, 4'b0000, 3'd1, 16'd0,     16'd0,     4'b0010};
        tbl[18] = '{4'b0000, 4'b0000, 3'd1, 16'd30000, 16'd30000, 4'b0010};
        tbl[19] = '{4'b0000, 4'b0000, 3'd1, 16'd60000, 16'd60000, 4'b0010};
        tbl[20] = '{4'b0000, 4'b0000, 3'd1, 16'd65535, 16'd65535, 4'b0010};
        tbl[21] = '{4'b0000, 4'b0000, 3'd1, 16'd65535, 16'd65535, 4'b0010};
        tbl[22] = '{4'b0010, 4'b0000, 3'd1, 16'd0,     16'd65535, 4'b0010};
        tbl[23] = '{4'b0000, 4'b0000, 3'd1, 16'd30000, 16'd65535, 4'b0010};
        tbl[24] = '{4'b0000, 4'b0000, 3'd4, 16'd0,     16'd0,     4'b0010};
        tbl[25] = '{4'b0000, 4'b0000, 3'd0, 16'd0,     16'd0,     4'b0010};
        tbl[26] = '{4'b0000, 4'b0001, 3'd0, 16'd0,     16'd0,     4'b0010};

        for (int s = 0; s < NS; s++) begin
            rate_tab[s] = 0;
            dur_tab[s]  = 1;
        end
        rate_tab[0] = 30000;
        dur_tab[0]  = 3;
        rate_tab[2] = -20000;
        dur_tab[2]  = 10;
        sus_stage = 0;
        rel_stage = 2;
        pack_tabs();
        bus0.key_on_i  = '0;
        bus0.key_off_i = '0;
        bus0.rd_voice_i = 3'd1;
        m_cnt = 0;
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_rd_gain", 32'(bus0.rd_gain_o), 32'd0);
        chk("reset_active",  32'(bus0.active_o),  32'd0);
        chk("reset_tick",    32'(bus0.tick_o),    32'd0);
        rst = 1'b0;
        cyc();
        chk("first_tick", 32'(bus0.tick_o), 32'd1);

        // Directed vectors: each row is one full tick starting at the slot of voice 1
        for (int i = 0; i < 27; i++) begin
            sync_tick();
            bus0.key_on_i   = tbl[i].kon;
            bus0.key_off_i  = tbl[i].koff;
            bus0.rd_voice_i = tbl[i].rd;
            cyc();
            bus0.key_on_i  = '0;
            bus0.key_off_i = '0;
            repeat (TC - 1) cyc();
            chk($sformatf("vec%0d_gain_m0", i), 32'(bus0.rd_gain_o), 32'(tbl[i].g0));
            chk($sformatf("vec%0d_gain_m1", i), 32'(bus1.rd_gain_o), 32'(tbl[i].g1));
            chk($sformatf("vec%0d_active", i),  32'(bus0.active_o),  32'(tbl[i].act));
        end

        // Reset in the middle of a note with a key-off still pending
        sync_tick();
        bus0.rd_voice_i = 3'd1;
        bus0.key_on_i   = 4'b0010;
        cyc();
        bus0.key_on_i  = '0;
        bus0.key_off_i = 4'b0010;
        cyc();
        bus0.key_off_i = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_gain_m0", 32'(bus0.rd_gain_o), 32'd0);
        chk("midrst_gain_m1", 32'(bus1.rd_gain_o), 32'd0);
        chk("midrst_active",  32'(bus0.active_o),  32'd0);
        cyc();
        chk("midrst_first_tick", 32'(bus0.tick_o), 32'd1);
        repeat (3*TC) cyc();
        chk("midrst_no_release_gain",   32'(bus0.rd_gain_o), 32'd0);
        chk("midrst_no_release_active", 32'(bus1.active_o),  32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus0.key_on_i   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            bus0.key_off_i  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            bus0.rd_voice_i = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) begin
                rate_tab[$urandom_range(0, NS-1)] = int'($urandom_range(0, 80000)) - 40000;
                dur_tab[$urandom_range(0, NS-1)]  = int'($urandom_range(0, 5));
                sus_stage = int'($urandom_range(0, NS-1));
                rel_stage = int'($urandom_range(0, NS-1));
                pack_tabs();
            end
            rst = ($urandom_range(0, 799) == 0);
            cyc();
        end
        rst = 1'b0;
        bus0.key_on_i  = '0;
        bus0.key_off_i = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
